seven_segment_reader: RTL and testbench

Capture block for the multiplexed seven-segment display bus: watches the active-low segment lines and the active-low digit anodes, waits for each scanned digit to hold steady, and decodes the segment pattern back to a hex nibble. It collects the four scanned digits into a 16-bit word and pulses a frame strobe when all four are present. It sits beside the display driver on the board-level bus and serves as the self-check and loopback monitor for the front-panel display path.

---
 rtl/seven_segment_reader.sv | 207 ++++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader
// Loopback monitor for a multiplexed, active-low seven-segment display bus.
// Waits for each scanned digit to hold steady, decodes the segment pattern
// back to a hex nibble, gathers four digits into a 16-bit word and pulses
// frame_valid when a full frame has been seen.
//
// Build option: define SEVEN_SEGMENT_READER_BLANK_EN to accept the all-off
// pattern (7F) as a legal blank digit (nibble 0, no error).
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_COUNT,
        ST_HOLD
    } state_t;

    // Returns {err, nibble} for a registered segment pattern (seg[6]=a .. seg[0]=g).
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h01: decode = 5'h00;
            7'h4F: decode = 5'h01;
            7'h12: decode = 5'h02;
            7'h06: decode = 5'h03;
            7'h4C: decode = 5'h04;
            7'h24: decode = 5'h05;
            7'h20: decode = 5'h06;
            7'h0F: decode = 5'h07;
            7'h00: decode = 5'h08;
            7'h04: decode = 5'h09;
            7'h08: decode = 5'h0A;
            7'h60: decode = 5'h0B;
            7'h31: decode = 5'h0C;
            7'h42: decode = 5'h0D;
            7'h30: decode = 5'h0E;
            7'h38: decode = 5'h0F;
`ifdef SEVEN_SEGMENT_READER_BLANK_EN
            7'h7F: decode = 5'h00;
`endif
            default: decode = 5'h10;
        endcase
    endfunction

    // Registered state
    logic [6:0]  s_seg_q, s_seg_d;
    logic [3:0]  s_an_q,  s_an_d;
    logic [6:0]  p_seg_q, p_seg_d;   // previous s_seg sample
    logic [3:0]  p_an_q,  p_an_d;    // previous s_an sample
    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  digit_err_q, digit_err_d;
    logic [3:0]  mask_q,  mask_d;
    logic        ferr_q,  ferr_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q,   frame_err_d;

    // Decision helpers
    logic        an_ok;
    logic        an_same;
    logic        seg_same;
    logic        capture;
    logic [1:0]  idx;
    logic [4:0]  dec;

    // Input stage: sample the pins and keep one older copy for change detection.
    always_comb begin
        s_seg_d = seg;
        s_an_d  = an;
        p_seg_d = s_seg_q;
        p_an_d  = s_an_q;
    end

    // Anode qualification: which digit is selected and whether anything moved.
    always_comb begin
        an_ok    = 1'b1;
        idx      = 2'd0;
        case (s_an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: an_ok = 1'b0;
        endcase
        an_same  = (s_an_q == p_an_q);
        seg_same = (s_seg_q == p_seg_q);
        dec      = decode(s_seg_q);
    end

    // Stability FSM: count identical one-hot samples and flag the capture cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                cnt_d = 8'd0;
                if (an_ok) begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
            end
            ST_COUNT: begin
                if (!an_ok) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else if (an_same && seg_same) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd1;
                end
            end
            ST_HOLD: begin
                if (!an_ok) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else if (!(an_same && seg_same)) begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
            end
        endcase
        // Reaching the threshold captures on this same edge, including the
        // single-sample case where the count has just restarted at 1.
        if (state_d == ST_COUNT && cnt_d == 8'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    // Capture and frame assembly.
    always_comb begin
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        mask_d        = mask_q;
        ferr_d        = ferr_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        if (capture) begin
            value_d[{idx, 2'b00} +: 4] = dec[3:0];
            digit_err_d[idx]           = dec[4];
            mask_d[idx]                = 1'b1;
            ferr_d                     = ferr_q | dec[4];
            if (mask_d == 4'hF) begin
                frame_valid_d = 1'b1;
                frame_err_d   = ferr_d;
                mask_d        = 4'h0;
                ferr_d        = 1'b0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            s_seg_q       <= 7'h7F;
            s_an_q        <= 4'hF;
            p_seg_q       <= 7'h7F;
            p_an_q        <= 4'hF;
            state_q       <= ST_WAIT;
            cnt_q         <= 8'd0;
            value_q       <= 16'h0000;
            digit_err_q   <= 4'h0;
            mask_q        <= 4'h0;
            ferr_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            s_seg_q       <= s_seg_d;
            s_an_q        <= s_an_d;
            p_seg_q       <= p_seg_d;
            p_an_q        <= p_an_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            mask_q        <= mask_d;
            ferr_q        <= ferr_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign value       = value_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (STABLE_CYCLES = 4).
// Expected frames are pushed to a scoreboard queue as digits are scanned and
// popped by a monitor whenever frame_valid pulses.
module tb_seven_segment_reader;

    localparam int S = 4;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic        f;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int frames_seen = 0;
    int frames_exp  = 0;

    frame_t      exp_q[$];
    logic [15:0] m_value = 16'h0;
    logic [3:0]  m_derr  = 4'h0;
    logic [3:0]  m_mask  = 4'h0;
    logic        m_ferr  = 1'b0;
    logic        fv_prev = 1'b0;

    seven_segment_reader #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode: {err, nibble}
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h01: return 5'h00;  7'h4F: return 5'h01;
            7'h12: return 5'h02;  7'h06: return 5'h03;
            7'h4C: return 5'h04;  7'h24: return 5'h05;
            7'h20: return 5'h06;  7'h0F: return 5'h07;
            7'h00: return 5'h08;  7'h04: return 5'h09;
            7'h08: return 5'h0A;  7'h60: return 5'h0B;
            7'h31: return 5'h0C;  7'h42: return 5'h0D;
            7'h30: return 5'h0E;  7'h38: return 5'h0F;
`ifdef SEVEN_SEGMENT_READER_BLANK_EN
            7'h7F: return 5'h00;
`endif
            default: return 5'h10;
        endcase
    endfunction

    task automatic model_capture(input int i, input logic [6:0] p);
        logic [4:0] r;
        frame_t     fr;
        r = ref_decode(p);
        m_value[i*4 +: 4] = r[3:0];
        m_derr[i]         = r[4];
        m_mask[i]         = 1'b1;
        m_ferr            = m_ferr | r[4];
        if (m_mask == 4'hF) begin
            fr.v = m_value;
            fr.d = m_derr;
            fr.f = m_ferr;
            exp_q.push_back(fr);
            frames_exp++;
            m_mask = 4'h0;
            m_ferr = 1'b0;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int i, input logic [6:0] p);
        model_capture(i, p);
        drive(4'(~(4'b0001 << i)), p, 2 * S);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid && fv_prev) check("fv_back_to_back", 32'(frame_valid), 32'd0);
            if (frame_valid) begin
                frame_t e;
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(frames_seen), 32'(frames_exp));
                end else begin
                    e = exp_q.pop_front();
                    check("frame_value", 32'(value), 32'(e.v));
                    check("frame_err", 32'(frame_err), 32'(e.f));
                    check("frame_digit_err", 32'(digit_err), 32'(e.d));
                end
            end
        end
        fv_prev = frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_digit_err", 32'(digit_err), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        drive(4'hF, 7'h7F, 2);

        // Basic scan 1,2,3,4
        scan(0, 7'h4F);
        scan(1, 7'h12);
        scan(2, 7'h06);
        scan(3, 7'h4C);
        check("scan_value", 32'(value), 32'h4321);
        check("scan_digit_err", 32'(digit_err), 32'h0);

        // 08 briefly, then 60: only B is captured, S edges after the change
        model_capture(2, 7'h60);
        drive(4'b1011, 7'h08, 3);
        drive(4'b1011, 7'h60, S);
        check("latency_before", 32'(value[11:8]), 32'h3);
        drive(4'b1011, 7'h60, 1);
        check("latency_at", 32'(value[11:8]), 32'hB);
        drive(4'b1011, 7'h60, 1);

        // Bad pattern on anode 1 completes a frame with frame_err
        scan(0, 7'h01);
        scan(1, 7'h7E);
        scan(3, 7'h0F);
        check("bad_digit_err", 32'(digit_err), 32'h2);
        check("bad_value_d1", 32'(value[7:4]), 32'h0);

        // Two anodes low: no capture, mask survives
        scan(0, 7'h12);
        scan(1, 7'h06);
        drive(4'b1100, 7'h00, 10);
        check("ghost_value", 32'(value), 32'h7B32);
        scan(2, 7'h24);
        scan(3, 7'h20);

        // Reset after three digits
        scan(0, 7'h00);
        scan(1, 7'h04);
        scan(2, 7'h08);
        rst = 1'b1;
        drive(4'hF, 7'h7F, 1);
        rst = 1'b0;
        m_value = 16'h0; m_derr = 4'h0; m_mask = 4'h0; m_ferr = 1'b0;
        check("mid_rst_value", 32'(value), 32'h0);
        check("mid_rst_digit_err", 32'(digit_err), 32'h0);
        check("mid_rst_frame_valid", 32'(frame_valid), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        scan(3, 7'h60);
        scan(0, 7'h31);
        scan(1, 7'h42);
        scan(2, 7'h30);

        // All-blank frame
        scan(0, 7'h7F);
        scan(1, 7'h7F);
        scan(2, 7'h7F);
        scan(3, 7'h7F);
        check("blank_value", 32'(value), 32'(m_value));
        check("blank_digit_err", 32'(digit_err), 32'(m_derr));

        drive(4'hF, 7'h7F, 5);
        check("frames_pending", 32'(exp_q.size()), 32'd0);
        check("frames_count", 32'(frames_seen), 32'(frames_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
